rr_stream_mux: RTL
==================

// Module: rr_stream_mux
// PURPOSE
//   Parametrised N:1 stream multiplexer with round-robin arbitration and a registered output.
//   Generalises the fixed 4:1 case-based select to NUM_CH channels of DATA_W bits.
//   Adds a valid/ready handshake on every input and on the output.
//   Sits between several producer streams and one shared consumer (bus, FIFO, serialiser).
// PARAMETERS
//   NUM_CH  4  number of input channels, >= 1; need not be a power of two
//   DATA_W  8  data width per channel, >= 1
//   CH_W    derived: (NUM_CH>1) ? $clog2(NUM_CH) : 1; localparam, not overridable
// PORTS
//   clk        in   1              rising-edge clock
//   rst_n      in   1              asynchronous active-low reset
//   in_valid   in   NUM_CH         bit i: channel i offers a beat
//   in_data    in   NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
//   in_ready   out  NUM_CH         bit i: channel i beat accepted this cycle
//   out_valid  out  1              output register holds a beat
//   out_data   out  DATA_W         registered data
//   out_ch     out  CH_W           source channel of out_data
//   out_ready  in   1              consumer accepts out_data
// BEHAVIOUR
//   Reset (async assert, sync release):
//     out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
//     in_ready=0 while rst_n=0. Any held beat is discarded.
//   load = ~out_valid | out_ready   (output register empty or draining this cycle).
//   Grant (combinational):
//     - Search for the first i with in_valid[i], starting at ptr and wrapping NUM_CH-1 -> 0.
//     - No valid channel gives no grant.
//   in_ready[i] = load & grant[i]. At most one bit is set (one-hot or zero).
//     - in_ready must not be used to gate in_valid, to avoid a combinational loop.
//   On a clk edge with load=1 and a grant to channel g:
//     - out_data <= slice g; out_ch <= g; out_valid <= 1.
//     - ptr <= (g==NUM_CH-1) ? 0 : g+1. Use an explicit compare, not a modulo.
//   On a clk edge with load=1 and no grant: out_valid <= 0; out_data and out_ch hold; ptr holds.
//   On a clk edge with load=0 (stall): all registers hold.
//     - out_data and out_ch are stable while out_valid & ~out_ready.
//   State machine (encoded by out_valid):
//     - EMPTY -> FULL on a grant.
//     - FULL -> FULL on out_ready with a grant, or on a stall.
//     - FULL -> EMPTY on out_ready with no grant.
//   Latency: accepted beat appears on the output 1 cycle later.
//   Throughput: 1 beat/cycle while out_ready=1.
//   Fairness: each continuously-valid channel is granted within NUM_CH accepted beats.
//   NUM_CH=1: grant = in_valid[0]; ptr stays 0; out_ch is always 0.
// CONFIGURATION
//   RR_STREAM_MUX_FIXED_PRIO_EN
//     Defined: fixed priority, lowest valid index wins. ptr logic is removed.
//     Undefined (default): round-robin as described above.
//     Handshake, latency and reset are identical in both builds.
// TESTING  (NUM_CH=4, DATA_W=8 unless noted)
//   1. Reset: hold rst_n=0 with in_valid=4'hF
//      -> out_valid=0, out_data=8'h00, out_ch=0, in_ready=4'b0000.
//   2. Single beat: in_valid=4'b0100, ch2 data=8'hA5, out_ready=1
//      -> in_ready=4'b0100 in the same cycle.
//      -> next cycle out_valid=1, out_data=8'hA5, out_ch=2.
//   3. Round-robin: in_valid=4'hF held, out_ready=1, data[i]=8'h10+i
//      -> out_ch sequence 0,1,2,3,0; out_data 8'h10,11,12,13,10 on consecutive cycles.
//   4. Backpressure: out_valid=1 (out_ch=1, 8'h11), out_ready=0 for 3 cycles
//      -> out_data/out_ch stable; in_ready=4'b0000.
//      -> out_ready=1 gives the next beat (ch2) on the following cycle.
//   5. Wrap and empty: ptr=3, in_valid=4'b0011 -> ch0 granted, ptr becomes 1.
//      -> then in_valid=0 with out_ready=1 -> out_valid drops to 0 the next cycle.
//   6. Reset mid-stream: pulse rst_n low during scenario 3
//      -> out_valid=0 immediately, without waiting for clk.
//      -> after release the first grant is ch0.
//      -> with RR_STREAM_MUX_FIXED_PRIO_EN and in_valid=4'hF, out_ch=0 every beat.

Source files
------------

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N:1 valid/ready stream mux, round-robin grant, registered output.
// Define RR_STREAM_MUX_FIXED_PRIO_EN for fixed lowest-index-wins priority (no rr pointer).
module rr_stream_mux #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
);
  logic              load, found, nxt_valid;
  logic [CH_W-1:0]   gnt, nxt_ch;
  logic [DATA_W-1:0] sel, nxt_data;
  assign load = ~out_valid | out_ready;
`ifndef RR_STREAM_MUX_FIXED_PRIO_EN
  logic [CH_W-1:0] ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (load && found) ptr <= (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
`endif
  // Lowest valid index wins; the second pass overrides with the lowest valid index at or above ptr.
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (in_valid[i]) begin
        found = 1'b1;
        gnt = CH_W'(i);
      end
`ifndef RR_STREAM_MUX_FIXED_PRIO_EN
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (in_valid[i] && CH_W'(i) >= ptr) gnt = CH_W'(i);
`endif
  end
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (gnt == CH_W'(i)) sel = in_data[i*DATA_W +: DATA_W];
  end
  always_comb begin
    nxt_valid = load ? found : out_valid;
    nxt_data = (load && found) ? sel : out_data;
    nxt_ch = (load && found) ? gnt : out_ch;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
    end else begin
      out_valid <= nxt_valid;
      out_data <= nxt_data;
      out_ch <= nxt_ch;
    end
  always_comb
    for (int i = 0; i < NUM_CH; i++)
      in_ready[i] = rst_n & load & found & (gnt == CH_W'(i));
endmodule
